// File: rtl/branch_unit_pkg.sv
// Shared B-type funct3 encodings for the branch resolution path.
package f3Br;

    localparam logic [2:0] EQ  = 3'b000;
    localparam logic [2:0] NE  = 3'b001;
    localparam logic [2:0] LT  = 3'b100;
    localparam logic [2:0] GE  = 3'b101;
    localparam logic [2:0] LTU = 3'b110;
    localparam logic [2:0] GEU = 3'b111;

    typedef logic [2:0] funct3_t;

endpackage

// File: rtl/branch_unit_cmp.sv
// Pure combinational branch comparator: evaluates the funct3-selected condition
// and flags the two reserved encodings.
module branch_cmp
    import f3Br::*;
#(
    parameter int XLEN = 32
) (
    input  funct3_t          funct3,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    output logic             cond,
    output logic             reserved
);

    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;

    assign w_eq   = (rs1 == rs2);
    assign w_lt_s = ($signed(rs1) < $signed(rs2));
    assign w_lt_u = (rs1 < rs2);

    // NOTE: both outputs get a default first so no path through the case infers a latch.
    always_comb begin
        cond     = 1'b0;
        reserved = 1'b0;
        case (funct3)
            EQ:      cond = w_eq;
            NE:      cond = ~w_eq;
            LT:      cond = w_lt_s;
            GE:      cond = ~w_lt_s;
            LTU:     cond = w_lt_u;
            GEU:     cond = ~w_lt_u;
            default: reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch resolution: qualified condition, target/next-pc adders,
// registered last resolution and saturating event counters.
module branch_unit
    import f3Br::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch,
    input  funct3_t           funct3,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic              pred_taken,
    output logic              taken,
    output logic [XLEN-1:0]   target,
    output logic [XLEN-1:0]   next_pc,
    output logic              mispredict,
    output logic              illegal,
    output logic              res_valid,
    output logic              res_taken,
    output logic [XLEN-1:0]   res_target,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  taken_count,
    output logic [CNT_W-1:0]  mispred_count
);

    logic            w_cond;
    logic            w_reserved;
    logic [XLEN-1:0] w_pc_plus4;
    logic [2:0]      w_inc;

    logic            r_res_valid;
    logic            r_res_taken;
    logic [XLEN-1:0] r_res_target;
    logic [CNT_W-1:0] r_cnt [3];

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3   (funct3),
        .rs1      (rs1),
        .rs2      (rs2),
        .cond     (w_cond),
        .reserved (w_reserved)
    );

    // Adders wrap silently modulo 2^XLEN; target is valid even when branch is low.
    assign target     = pc + imm;
    assign w_pc_plus4 = pc + XLEN'(4);

    assign taken      = branch & w_cond & ~w_reserved;
    assign illegal    = branch & w_reserved;
    assign mispredict = branch & (taken ^ pred_taken);
    assign next_pc    = taken ? target : w_pc_plus4;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid  <= 1'b0;
            r_res_taken  <= 1'b0;
            r_res_target <= '0;
        end else begin
            r_res_valid <= branch;
            if (branch) begin
                r_res_taken  <= taken;
                r_res_target <= next_pc;
            end
        end
    end

    // Counter 0 counts every branch (illegal included), 1 taken, 2 mispredicted.
    assign w_inc = {mispredict, taken, branch};

    for (genvar g = 0; g < 3; g++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt[g] <= '0;
            end else if (w_inc[g] && (r_cnt[g] != '1)) begin
                r_cnt[g] <= r_cnt[g] + CNT_W'(1);
            end
        end
    end

    assign res_valid     = r_res_valid;
    assign res_taken     = r_res_taken;
    assign res_target    = r_res_target;
    assign br_count      = r_cnt[0];
    assign taken_count   = r_cnt[1];
    assign mispred_count = r_cnt[2];

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: a driver pushes model expectations, a
// negedge monitor pops and compares; a 3-bit-counter instance exercises saturation.
module tb_branch_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;
    localparam int SAT_W = 3;
    localparam logic [31:0] MAX_MAIN = 32'hFFFF_FFFF;
    localparam logic [31:0] MAX_SAT  = 32'd7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             branch;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rs1, rs2, pc, imm;
    logic             pred_taken;

    logic             taken, mispredict, illegal, res_valid, res_taken;
    logic [XLEN-1:0]  target, next_pc, res_target;
    logic [CNT_W-1:0] br_count, taken_count, mispred_count;

    logic             s_taken, s_mispredict, s_illegal, s_res_valid, s_res_taken;
    logic [XLEN-1:0]  s_target, s_next_pc, s_res_target;
    logic [SAT_W-1:0] s_br_count, s_taken_count, s_mispred_count;

    branch_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .branch(branch), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .pred_taken(pred_taken),
        .taken(taken), .target(target), .next_pc(next_pc),
        .mispredict(mispredict), .illegal(illegal),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .br_count(br_count), .taken_count(taken_count), .mispred_count(mispred_count)
    );

    branch_unit #(.XLEN(XLEN), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .branch(branch), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .pred_taken(pred_taken),
        .taken(s_taken), .target(s_target), .next_pc(s_next_pc),
        .mispredict(s_mispredict), .illegal(s_illegal),
        .res_valid(s_res_valid), .res_taken(s_res_taken), .res_target(s_res_target),
        .br_count(s_br_count), .taken_count(s_taken_count), .mispred_count(s_mispred_count)
    );

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [31:0] next_pc;
        logic        mispred;
        logic        illegal;
    } comb_t;

    typedef struct {
        logic        valid;
        logic        rtaken;
        logic [31:0] rtarget;
        logic [31:0] br, tk, mp;
        logic [31:0] sbr, stk, smp;
    } regs_t;

    typedef struct {
        comb_t c;
        regs_t r;
    } exp_t;

    exp_t  sb_q[$];
    regs_t model;
    regs_t held;
    bit    have_held;
    int    checks;
    int    failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
        return (v == maxv) ? v : v + 32'd1;
    endfunction

    // Reference behaviour straight from the branch rules.
    function automatic comb_t ref_comb(input logic b, input logic [2:0] f,
                                       input logic [31:0] a, input logic [31:0] c,
                                       input logic [31:0] p, input logic [31:0] i,
                                       input logic pr);
        comb_t r;
        bit cond;
        bit rsv;
        int sa;
        int sc;
        sa   = int'(a);
        sc   = int'(c);
        cond = 0;
        rsv  = 0;
        case (f)
            3'd0: cond = (a == c);
            3'd1: cond = (a != c);
            3'd4: cond = (sa < sc);
            3'd5: cond = (sa >= sc);
            3'd6: cond = (a < c);
            3'd7: cond = (a >= c);
            default: rsv = 1;
        endcase
        r.taken   = b && cond;
        r.illegal = b && rsv;
        r.mispred = b && (r.taken != pr);
        r.target  = p + i;
        r.next_pc = r.taken ? (p + i) : (p + 32'd4);
        return r;
    endfunction

    task automatic update_model(input logic b, input comb_t c);
        model.valid = b;
        if (b) begin
            model.rtaken  = c.taken;
            model.rtarget = c.next_pc;
            model.br  = sat_inc(model.br, MAX_MAIN);
            model.sbr = sat_inc(model.sbr, MAX_SAT);
            if (c.taken) begin
                model.tk  = sat_inc(model.tk, MAX_MAIN);
                model.stk = sat_inc(model.stk, MAX_SAT);
            end
            if (c.mispred) begin
                model.mp  = sat_inc(model.mp, MAX_MAIN);
                model.smp = sat_inc(model.smp, MAX_SAT);
            end
        end
    endtask

    task automatic set_inputs(input logic b, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] c, input logic [31:0] p,
                              input logic [31:0] i, input logic pr);
        branch = b; funct3 = f; rs1 = a; rs2 = c; pc = p; imm = i; pred_taken = pr;
    endtask

    task automatic drive(input logic b, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] c, input logic [31:0] p,
                         input logic [31:0] i, input logic pr);
        exp_t e;
        @(posedge clk);
        #1;
        set_inputs(b, f, a, c, p, i, pr);
        e.c = ref_comb(b, f, a, c, p, i, pr);
        update_model(b, e.c);
        e.r = model;
        sb_q.push_back(e);
    endtask

    task automatic clear_model();
        model = '{valid: 1'b0, rtaken: 1'b0, rtarget: 32'd0, br: 32'd0, tk: 32'd0,
                  mp: 32'd0, sbr: 32'd0, stk: 32'd0, smp: 32'd0};
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_taken"}, 32'(res_taken), 32'd0);
        check({tag, "_res_target"}, res_target, 32'd0);
        check({tag, "_br_count"}, br_count, 32'd0);
        check({tag, "_taken_count"}, taken_count, 32'd0);
        check({tag, "_mispred_count"}, mispred_count, 32'd0);
        check({tag, "_sat_br_count"}, 32'(s_br_count), 32'd0);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
        check(tag, sb_q.size(), 32'd0);
    endtask

    // Monitor: combinational results now, registered results one negedge later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("taken", 32'(taken), 32'(e.c.taken));
                check("target", target, e.c.target);
                check("next_pc", next_pc, e.c.next_pc);
                check("mispredict", 32'(mispredict), 32'(e.c.mispred));
                check("illegal", 32'(illegal), 32'(e.c.illegal));
                if (have_held) begin
                    check("res_valid", 32'(res_valid), 32'(held.valid));
                    check("res_taken", 32'(res_taken), 32'(held.rtaken));
                    check("res_target", res_target, held.rtarget);
                    check("br_count", br_count, held.br);
                    check("taken_count", taken_count, held.tk);
                    check("mispred_count", mispred_count, held.mp);
                    check("sat_br_count", 32'(s_br_count), held.sbr);
                    check("sat_taken_count", 32'(s_taken_count), held.stk);
                    check("sat_mispred_count", 32'(s_mispred_count), held.smp);
                end
                held      = e.r;
                have_held = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, c, p, i;
        logic [2:0]  f;
        checks    = 0;
        failures  = 0;
        have_held = 1'b0;
        clear_model();
        set_inputs(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        rst_n = 1'b0;
        #12;
        check_regs_zero("reset");
        rst_n = 1'b1;

        // Taken set
        drive(1, 3'b000, 32'hdeadbeef, 32'hdeadbeef, 32'h1000, 32'hFFFF_FFF0, 1);
        drive(1, 3'b001, 32'hbeeff00d, 32'hcafef00d, 32'h2000, 32'h0000_0040, 1);
        drive(1, 3'b100, 32'hfedcba98, 32'h12345678, 32'h2004, 32'h0000_0010, 1);
        drive(1, 3'b101, 32'h76543210, 32'hfedcba98, 32'h2008, 32'hFFFF_FF00, 0);
        drive(1, 3'b110, 32'h76543210, 32'h87654321, 32'h200c, 32'h0000_0100, 1);
        drive(1, 3'b111, 32'hfedcba98, 32'h01234567, 32'h2010, 32'h0000_0008, 1);
        // Not-taken set
        drive(1, 3'b000, 32'hfeedf00d, 32'hf00dfeed, 32'h1000, 32'hFFFF_FFF0, 0);
        drive(1, 3'b001, 32'hfeedc0de, 32'hfeedc0de, 32'h3000, 32'h0000_0020, 1);
        drive(1, 3'b100, 32'h76543210, 32'h87654321, 32'h3004, 32'h0000_0020, 0);
        drive(1, 3'b101, 32'hfedcba98, 32'h01234567, 32'h3008, 32'h0000_0020, 0);
        drive(1, 3'b110, 32'hfedcba98, 32'h12345678, 32'h300c, 32'h0000_0020, 1);
        drive(1, 3'b111, 32'h76543210, 32'hfedcba98, 32'hFFFF_FFFC, 32'h0000_0020, 0);
        // Gating, reserved encodings
        drive(0, 3'b000, 32'h12345678, 32'h12345678, 32'h4000, 32'h0000_0080, 0);
        drive(1, 3'b010, 32'h12345678, 32'h12345678, 32'h4004, 32'h0000_0080, 1);
        drive(1, 3'b011, 32'h00000001, 32'h00000002, 32'h4008, 32'h0000_0080, 0);

        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            c = ($urandom_range(0, 3) == 0) ? a : $urandom;
            p = $urandom & 32'hFFFF_FFFC;
            i = $urandom & 32'hFFFF_FFFE;
            f = 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 3) != 0), f, a, c, p, i, 1'($urandom_range(0, 1)));
        end
        drain("drain_random");

        // Mid-cycle reset pulse, then a branch captured on the first edge after release.
        @(posedge clk);
        #1;
        set_inputs(1, 3'b000, 32'h5, 32'h5, 32'h1000, 32'hFFFF_FFF0, 0);
        #1 rst_n = 1'b0;
        #1;
        check_regs_zero("async_reset");
        #1 rst_n = 1'b1;
        clear_model();
        update_model(1'b1, ref_comb(1, 3'b000, 32'h5, 32'h5, 32'h1000, 32'hFFFF_FFF0, 0));
        held      = model;
        have_held = 1'b1;

        // Saturation: 3-bit counters climb to 5, then three more branches stop at 7.
        for (int n = 0; n < 7; n++)
            drive(1, 3'b000, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h8000, 32'h0000_0010, 0);
        drive(0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        drive(0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        drain("drain_final");
        @(negedge clk);
        #1;
        check("final_sat_br", 32'(s_br_count), 32'd7);
        check("final_sat_taken", 32'(s_taken_count), 32'd7);
        check("final_sat_mispred", 32'(s_mispred_count), 32'd7);
        check("final_br", br_count, 32'd8);
        check("final_mispred", mispred_count, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
# branch_unit

Branch resolution unit for the execute stage of the RV32I core. It compares two 32-bit register operands according to the B-type `funct3` and raises `taken` combinationally. It also computes the branch target and misprediction flag, and keeps a registered copy of the last resolution plus event counters for the front end and debug.

## Interface
Parameters:
- `XLEN`, 32: operand and address width.
- `CNT_W`, 32: width of the event counters.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `branch` in 1: the current instruction is a conditional branch; it qualifies every output.
- `funct3` in 3: comparison select, `f3Br` encoding.
- `rs1` in XLEN: first operand.
- `rs2` in XLEN: second operand.
- `pc` in XLEN: address of the branch instruction.
- `imm` in XLEN: sign-extended B-immediate, bit 0 = 0.
- `pred_taken` in 1: front-end prediction for this branch.
- `taken` out 1: branch condition true, combinational.
- `target` out XLEN: `pc + imm`, combinational.
- `next_pc` out XLEN: `target` if `taken`, else `pc + 4`.
- `mispredict` out 1: `branch & (taken ^ pred_taken)`.
- `illegal` out 1: `branch` asserted with `funct3` equal to 010 or 011.
- `res_valid` out 1: registered; a branch resolved last cycle.
- `res_taken` out 1: registered `taken`.
- `res_target` out XLEN: registered `next_pc`.
- `br_count` out CNT_W: branches resolved, saturating.
- `taken_count` out CNT_W: taken branches, saturating.
- `mispred_count` out CNT_W: mispredictions, saturating.

## Operation
- Condition by `funct3`:
  - EQ 000: `rs1 == rs2`.
  - NE 001: `rs1 != rs2`.
  - LT 100: signed `rs1 < rs2`.
  - GE 101: signed `rs1 >= rs2`.
  - LTU 110: unsigned `rs1 < rs2`.
  - GEU 111: unsigned `rs1 >= rs2`.
- Reserved encodings 010/011: `taken` = 0 and `illegal` = 1.
- `branch` = 0: `taken`, `mispredict` and `illegal` are 0. `target` and `next_pc` are still computed.
- Arithmetic:
  - Signed compare uses two's complement.
  - Additions are modulo 2^XLEN; wrap-around is silent (for example `pc` 0xFFFFFFFC + 4 = 0).
- Counters:
  - Each counter increments by 1 on a clock edge where `branch` = 1 and its condition holds: every branch for `br_count`, `taken` for `taken_count`, `mispredict` for `mispred_count`.
  - `br_count` also counts `illegal` branches.
  - A counter at all-ones holds its value (saturates).
- There is no handshake: the inputs are sampled every cycle.

## Timing
- `taken`, `target`, `next_pc`, `mispredict` and `illegal` are purely combinational from the inputs with zero latency; they settle within the same cycle.
- `res_valid`, `res_taken`, `res_target` and the counters update on the rising `clk` edge, one cycle after the inputs.
- `res_valid` = `branch` from the previous cycle. `res_taken` and `res_target` load only when `branch` = 1 and otherwise hold.
- Reset values: `res_valid` 0, `res_taken` 0, `res_target` 0, all counters 0.
- Asserting `rst_n` low clears the registers immediately, regardless of `clk`. The combinational outputs are unaffected by reset.
- On the first edge after `rst_n` rises, normal capture resumes; a branch present on that edge is counted.

## Structure
- Shared package `f3Br` holds:
  - localparams `EQ`=3'b000, `NE`=3'b001, `LT`=3'b100, `GE`=3'b101, `LTU`=3'b110, `GEU`=3'b111;
  - a 3-bit typedef for `funct3`.
- One sub-module `branch_cmp`: a pure combinational comparator with inputs `funct3`, `rs1`, `rs2` and outputs `cond` and `reserved`.
- The top level adds qualification, target/`next_pc` adders, the resolution registers and three instances of a saturating-counter `always_ff` block.

## Test plan
- Taken set, `branch`=1, each expects `taken`=1:
  - EQ deadbeef/deadbeef;
  - NE beeff00d/cafef00d;
  - LT fedcba98/12345678;
  - GE 76543210/fedcba98;
  - LTU 76543210/87654321;
  - GEU fedcba98/01234567.
- Not-taken set, each expects `taken`=0:
  - EQ feedf00d/f00dfeed;
  - NE feedc0de/feedc0de;
  - LT 76543210/87654321;
  - GE fedcba98/01234567;
  - LTU fedcba98/12345678;
  - GEU 76543210/fedcba98.
- Gating and reserved encodings:
  - `branch`=0 with EQ and equal operands -> `taken`=0, `mispredict`=0.
  - `funct3`=010 -> `taken`=0, `illegal`=1.
- Target and next PC:
  - `pc`=0x1000, `imm`=0xFFFFFFF0, taken -> `target`=`next_pc`=0x0FF0.
  - Not taken -> `next_pc`=0x1004.
  - `pc`=0xFFFFFFFC, not taken -> `next_pc`=0.
- Registered path:
  - A taken branch with `pred_taken`=0 -> `mispredict`=1; next edge gives `res_valid`=1, `res_taken`=1, counters +1.
  - Pulsing `rst_n` low mid-cycle clears all registers before the next edge.
- Saturation: force the counters near all-ones, drive three branches -> counters stop at all-ones.
